// File: rtl/video_timing_pipe.sv
// rtl/video_timing_pipe.sv - raster timing generator with lead-time pixel requests and aligned encoder outputs
`timescale 1ns/1ps

module video_timing_pipe #(
  parameter int   H_DISP   = 1280,
  parameter int   H_FRONT  = 110,
  parameter int   H_SYNC   = 40,
  parameter int   H_BACK   = 220,
  parameter int   V_DISP   = 720,
  parameter int   V_FRONT  = 5,
  parameter int   V_SYNC   = 5,
  parameter int   V_BACK   = 20,
  parameter logic H_POL    = 1'b1,
  parameter logic V_POL    = 1'b1,
  parameter int   REQ_LEAD = 1,
  parameter int   CW       = 16,
  parameter int   FCW      = 8
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           en,
  output logic           req,
  output logic [CW-1:0]  req_x,
  output logic [CW-1:0]  req_y,
  input  logic [23:0]    rgb_in,
  output logic           de_o,
  output logic           hsync_o,
  output logic           vsync_o,
  output logic [23:0]    rgb_o,
  output logic           frame_start,
  output logic [FCW-1:0] frame_cnt
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;

  localparam logic [CW-1:0]  H_LAST    = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0]  V_LAST    = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0]  H_ACT     = CW'(H_SYNC + H_BACK);
  localparam logic [CW-1:0]  H_REQ     = CW'(H_SYNC + H_BACK - REQ_LEAD);
  localparam logic [CW-1:0]  V_ACT     = CW'(V_SYNC + V_BACK);
  localparam logic [CW-1:0]  H_DISP_W  = CW'(H_DISP);
  localparam logic [CW-1:0]  V_DISP_W  = CW'(V_DISP);
  localparam logic [CW-1:0]  H_SYNC_W  = CW'(H_SYNC);
  localparam logic [CW-1:0]  V_SYNC_W  = CW'(V_SYNC);
  localparam logic [CW-1:0]  ONE       = CW'(1);
  localparam logic [FCW-1:0] FONE      = FCW'(1);

  logic [CW-1:0] hc;
  logic [CW-1:0] vc;
  logic [CW-1:0] disp_x;
  logic [CW-1:0] lead_x;
  logic [CW-1:0] disp_y;
  logic          h_disp;
  logic          h_req;
  logic          v_disp;
  logic          disp;
  logic          origin;

  // Window tests use offset-then-compare: counts below the window start wrap to
  // large unsigned values and fall outside, so no lower-bound compare is needed.
  assign disp_x = hc - H_ACT;
  assign lead_x = hc - H_REQ;
  assign disp_y = vc - V_ACT;
  assign h_disp = (disp_x < H_DISP_W);
  assign h_req  = (lead_x < H_DISP_W);
  assign v_disp = (disp_y < V_DISP_W);
  assign disp   = en & h_disp & v_disp;
  assign origin = en & (hc == '0) & (vc == '0);

  assign req   = en & h_req & v_disp;
  assign req_x = req ? lead_x : '0;
  assign req_y = req ? disp_y : '0;

  // Raster counters: held at origin while disabled, line/frame wrap while running.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hc <= '0;
      vc <= '0;
    end else if (!en) begin
      hc <= '0;
      vc <= '0;
    end else if (hc == H_LAST) begin
      hc <= '0;
      vc <= (vc == V_LAST) ? '0 : vc + ONE;
    end else begin
      hc <= hc + ONE;
    end
  end

  // Registered encoder outputs, one cycle behind the counters; en gates them so
  // a dropped enable blanks the very next cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      de_o        <= 1'b0;
      hsync_o     <= ~H_POL;
      vsync_o     <= ~V_POL;
      rgb_o       <= '0;
      frame_start <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      de_o        <= disp;
      hsync_o     <= (en && (hc < H_SYNC_W)) ? H_POL : ~H_POL;
      vsync_o     <= (en && (vc < V_SYNC_W)) ? V_POL : ~V_POL;
      rgb_o       <= disp ? rgb_in : '0;
      frame_start <= origin;
      if (origin) begin
        frame_cnt <= frame_cnt + FONE;
      end
    end
  end

endmodule

// File: tb/tb_video_timing_pipe.sv
// tb/tb_video_timing_pipe.sv - scoreboard bench for video_timing_pipe on a 14x7 raster at three request leads
`timescale 1ns/1ps

module tb_video_timing_pipe;

  localparam int CW  = 16;
  localparam int FCW = 8;
  localparam logic [2:0] POL = 3'b101;

  logic clk = 1'b0;
  logic rstn;
  logic en;

  wire [2:0]               req;
  wire [2:0]               de;
  wire [2:0]               hs;
  wire [2:0]               vs;
  wire [2:0]               fs;
  wire [2:0][CW-1:0]       rx;
  wire [2:0][CW-1:0]       ry;
  wire [2:0][23:0]         rgb_o;
  wire [2:0][FCW-1:0]      fc;
  wire [2:0][23:0]         pix;
  logic [23:0]             rgb_in_l1;
  logic [23:0]             rgb_in_l4;
  logic [23:0]             dly [3];

  logic [23:0] sb [3][$];
  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  assign pix[0] = req[0] ? {ry[0][11:0], rx[0][11:0]} : 24'hFFFFFF;
  assign pix[1] = req[1] ? {ry[1][11:0], rx[1][11:0]} : 24'hFFFFFF;
  assign pix[2] = req[2] ? {ry[2][11:0], rx[2][11:0]} : 24'hFFFFFF;

  // Pixel source: answer each request after the lead time of its DUT.
  always @(posedge clk) begin
    rgb_in_l1 <= pix[0];
    dly[0]    <= pix[2];
    dly[1]    <= dly[0];
    dly[2]    <= dly[1];
    rgb_in_l4 <= dly[2];
  end

  video_timing_pipe #(.H_DISP(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
    .V_DISP(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .H_POL(1'b1), .V_POL(1'b1), .REQ_LEAD(1), .CW(CW), .FCW(FCW)) dut_l1 (
    .clk(clk), .rstn(rstn), .en(en), .req(req[0]), .req_x(rx[0]), .req_y(ry[0]),
    .rgb_in(rgb_in_l1), .de_o(de[0]), .hsync_o(hs[0]), .vsync_o(vs[0]),
    .rgb_o(rgb_o[0]), .frame_start(fs[0]), .frame_cnt(fc[0]));

  video_timing_pipe #(.H_DISP(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
    .V_DISP(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .H_POL(1'b0), .V_POL(1'b0), .REQ_LEAD(0), .CW(CW), .FCW(FCW)) dut_l0 (
    .clk(clk), .rstn(rstn), .en(en), .req(req[1]), .req_x(rx[1]), .req_y(ry[1]),
    .rgb_in(pix[1]), .de_o(de[1]), .hsync_o(hs[1]), .vsync_o(vs[1]),
    .rgb_o(rgb_o[1]), .frame_start(fs[1]), .frame_cnt(fc[1]));

  video_timing_pipe #(.H_DISP(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
    .V_DISP(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .H_POL(1'b1), .V_POL(1'b1), .REQ_LEAD(4), .CW(CW), .FCW(FCW)) dut_l4 (
    .clk(clk), .rstn(rstn), .en(en), .req(req[2]), .req_x(rx[2]), .req_y(ry[2]),
    .rgb_in(rgb_in_l4), .de_o(de[2]), .hsync_o(hs[2]), .vsync_o(vs[2]),
    .rgb_o(rgb_o[2]), .frame_start(fs[2]), .frame_cnt(fc[2]));

  function automatic int lead_of(input int i);
    case (i)
      0:       return 1;
      1:       return 0;
      default: return 4;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Idle-state checks shared by reset, disable and mid-frame reset scenarios are
  // written out in each task so each scenario owns its comparisons.
  task automatic test_reset();
    rstn = 1'b0;
    en   = 1'b0;
    repeat (3) tick();
    for (int i = 0; i < 3; i++) begin
      vectors++; if (de[i] !== 1'b0) begin errors++; $display("FAIL reset_de dut%0d got %b want 0", i, de[i]); end
      vectors++; if (rgb_o[i] !== 24'h0) begin errors++; $display("FAIL reset_rgb dut%0d got %h want 0", i, rgb_o[i]); end
      vectors++; if (hs[i] !== ~POL[i]) begin errors++; $display("FAIL reset_hs dut%0d got %b want %b", i, hs[i], ~POL[i]); end
      vectors++; if (vs[i] !== ~POL[i]) begin errors++; $display("FAIL reset_vs dut%0d got %b want %b", i, vs[i], ~POL[i]); end
      vectors++; if (fs[i] !== 1'b0) begin errors++; $display("FAIL reset_fs dut%0d got %b want 0", i, fs[i]); end
      vectors++; if (fc[i] !== '0) begin errors++; $display("FAIL reset_fc dut%0d got %0d want 0", i, fc[i]); end
      vectors++; if (req[i] !== 1'b0) begin errors++; $display("FAIL reset_req dut%0d got %b want 0", i, req[i]); end
    end
    rstn = 1'b1;
    repeat (2) tick();
    for (int i = 0; i < 3; i++) begin
      vectors++; if (fs[i] !== 1'b0) begin errors++; $display("FAIL idle_fs dut%0d got %b want 0", i, fs[i]); end
      vectors++; if (hs[i] !== ~POL[i]) begin errors++; $display("FAIL idle_hs dut%0d got %b want %b", i, hs[i], ~POL[i]); end
      vectors++; if (de[i] !== 1'b0) begin errors++; $display("FAIL idle_de dut%0d got %b want 0", i, de[i]); end
    end
  endtask

  // Runs n output cycles starting at raster origin; the cycle before the first
  // tick must be the first running cycle (hc=0, vc=0, en=1).
  task automatic run_frame(input int n, input logic [FCW-1:0] exp_cnt);
    int p, l, nh, hcur, vcur, ld, ex, ey;
    logic exp_de, exp_req, exp_hs, exp_vs;
    logic [23:0] want;
    int de_cnt [3];
    int hs_cnt [3];
    int vs_cnt [3];
    int fs_cnt [3];
    for (int i = 0; i < 3; i++) begin
      de_cnt[i] = 0; hs_cnt[i] = 0; vs_cnt[i] = 0; fs_cnt[i] = 0;
    end
    for (int k = 0; k < n; k++) begin
      tick();
      p      = k % 14;
      l      = k / 14;
      exp_de = (p >= 4) && (p < 12) && (l >= 2) && (l < 6);
      nh     = (k + 1) % 98;
      hcur   = nh % 14;
      vcur   = nh / 14;
      for (int i = 0; i < 3; i++) begin
        ld      = lead_of(i);
        exp_hs  = (p < 2) ? POL[i] : ~POL[i];
        exp_vs  = (l < 1) ? POL[i] : ~POL[i];
        exp_req = (hcur >= 4 - ld) && (hcur < 12 - ld) && (vcur >= 2) && (vcur < 6);
        ex      = exp_req ? hcur - (4 - ld) : 0;
        ey      = exp_req ? vcur - 2 : 0;
        vectors++; if (de[i] !== exp_de) begin errors++; $display("FAIL de dut%0d k=%0d got %b want %b", i, k, de[i], exp_de); end
        vectors++; if (hs[i] !== exp_hs) begin errors++; $display("FAIL hsync dut%0d k=%0d got %b want %b", i, k, hs[i], exp_hs); end
        vectors++; if (vs[i] !== exp_vs) begin errors++; $display("FAIL vsync dut%0d k=%0d got %b want %b", i, k, vs[i], exp_vs); end
        vectors++; if (fs[i] !== (k == 0)) begin errors++; $display("FAIL frame_start dut%0d k=%0d got %b want %b", i, k, fs[i], k == 0); end
        vectors++; if (fc[i] !== exp_cnt) begin errors++; $display("FAIL frame_cnt dut%0d k=%0d got %0d want %0d", i, k, fc[i], exp_cnt); end
        vectors++; if (req[i] !== exp_req) begin errors++; $display("FAIL req dut%0d k=%0d got %b want %b", i, k, req[i], exp_req); end
        vectors++; if (rx[i] !== CW'(ex) || ry[i] !== CW'(ey)) begin
          errors++; $display("FAIL req_xy dut%0d k=%0d got %0d,%0d want %0d,%0d", i, k, rx[i], ry[i], ex, ey);
        end
        vectors++;
        if (de[i]) begin
          if (sb[i].size() == 0) begin
            errors++; $display("FAIL rgb_sb_empty dut%0d k=%0d got %h want queued pixel", i, k, rgb_o[i]);
          end else begin
            want = sb[i].pop_front();
            if (rgb_o[i] !== want) begin errors++; $display("FAIL rgb dut%0d k=%0d got %h want %h", i, k, rgb_o[i], want); end
          end
        end else if (rgb_o[i] !== 24'h0) begin
          errors++; $display("FAIL rgb_blank dut%0d k=%0d got %h want 0", i, k, rgb_o[i]);
        end
        if (exp_req) sb[i].push_back({12'(ey), 12'(ex)});
        if (de[i]) de_cnt[i]++;
        if (hs[i] === POL[i]) hs_cnt[i]++;
        if (vs[i] === POL[i]) vs_cnt[i]++;
        if (fs[i]) fs_cnt[i]++;
      end
    end
    if (n == 98) begin
      for (int i = 0; i < 3; i++) begin
        vectors++; if (de_cnt[i] != 32) begin errors++; $display("FAIL de_total dut%0d got %0d want 32", i, de_cnt[i]); end
        vectors++; if (hs_cnt[i] != 14) begin errors++; $display("FAIL hs_total dut%0d got %0d want 14", i, hs_cnt[i]); end
        vectors++; if (vs_cnt[i] != 14) begin errors++; $display("FAIL vs_total dut%0d got %0d want 14", i, vs_cnt[i]); end
        vectors++; if (fs_cnt[i] != 1) begin errors++; $display("FAIL fs_total dut%0d got %0d want 1", i, fs_cnt[i]); end
        vectors++; if (sb[i].size() != 0) begin errors++; $display("FAIL sb_left dut%0d got %0d want 0", i, sb[i].size()); end
      end
    end
  endtask

  task automatic test_first_frame();
    en = 1'b1;
    run_frame(98, 8'd1);
  endtask

  task automatic test_back_to_back();
    run_frame(98, 8'd2);
  endtask

  task automatic test_en_drop();
    run_frame(48, 8'd3);
    en = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      vectors++; if (req[i] !== 1'b0) begin errors++; $display("FAIL drop_req dut%0d got %b want 0", i, req[i]); end
      vectors++; if (de[i] !== 1'b0) begin errors++; $display("FAIL drop_de dut%0d got %b want 0", i, de[i]); end
      vectors++; if (rgb_o[i] !== 24'h0) begin errors++; $display("FAIL drop_rgb dut%0d got %h want 0", i, rgb_o[i]); end
      vectors++; if (hs[i] !== ~POL[i] || vs[i] !== ~POL[i]) begin
        errors++; $display("FAIL drop_sync dut%0d got %b%b want %b%b", i, hs[i], vs[i], ~POL[i], ~POL[i]);
      end
      sb[i].delete();
    end
    repeat (3) tick();
    for (int i = 0; i < 3; i++) begin
      vectors++; if (fs[i] !== 1'b0) begin errors++; $display("FAIL drop_fs dut%0d got %b want 0", i, fs[i]); end
      vectors++; if (fc[i] !== 8'd3) begin errors++; $display("FAIL drop_fc dut%0d got %0d want 3", i, fc[i]); end
    end
    en = 1'b1;
    run_frame(98, 8'd4);
  endtask

  task automatic test_reset_mid();
    run_frame(34, 8'd5);
    rstn = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      vectors++; if (de[i] !== 1'b0) begin errors++; $display("FAIL areset_de dut%0d got %b want 0", i, de[i]); end
      vectors++; if (rgb_o[i] !== 24'h0) begin errors++; $display("FAIL areset_rgb dut%0d got %h want 0", i, rgb_o[i]); end
      vectors++; if (hs[i] !== ~POL[i] || vs[i] !== ~POL[i]) begin
        errors++; $display("FAIL areset_sync dut%0d got %b%b want %b%b", i, hs[i], vs[i], ~POL[i], ~POL[i]);
      end
      vectors++; if (fc[i] !== '0) begin errors++; $display("FAIL areset_fc dut%0d got %0d want 0", i, fc[i]); end
      vectors++; if (fs[i] !== 1'b0) begin errors++; $display("FAIL areset_fs dut%0d got %b want 0", i, fs[i]); end
      sb[i].delete();
    end
    rstn = 1'b1;
    run_frame(98, 8'd1);
  endtask

  task automatic test_frame_cnt_wrap();
    for (int f = 2; f <= 256; f++) begin
      run_frame(98, FCW'(f));
    end
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_back_to_back();
    test_en_drop();
    test_reset_mid();
    test_frame_cnt_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
